// File: rtl/branch_flag_ctrl.sv
// branch_flag_ctrl: resolves conditional branches against N/Z/V, stalling while a needed flag is in flight.
// Optional BRANCH_PERF_EN adds stall_cycles / taken_cnt performance counters.
module branch_flag_ctrl #(
    parameter int EX_LAT    = 2,
    parameter int STALL_MAX = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [3:0] issue_opcode,
    input  logic [2:0] flags,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    input  logic       fetch_ready,
    input  logic       flush,
    output logic       stall,
    output logic       br_resolved,
    output logic       br_taken,
    output logic       err
`ifdef BRANCH_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] taken_cnt
`endif
);
    // The write stage is covered by bypass, so only the stages before it are tracked.
    localparam int PD = (EX_LAT > 1) ? EX_LAT - 1 : 1;
    localparam int CW = ($clog2(STALL_MAX + 1) > 3) ? $clog2(STALL_MAX + 1) : 3;
    localparam logic [CW-1:0] SMAX = CW'(STALL_MAX);
    localparam logic [7:0][2:0] NEED = {3'b000, 3'b001, 3'b110, 3'b110,
                                        3'b100, 3'b110, 3'b010, 3'b010};

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           state, state_next;
    logic [PD-1:0][2:0] pend;
    logic [2:0]       mask, busy, need;
    logic [CW-1:0]    cnt;
    logic             n, z, v;
    logic             hazard, cond, held, wait_hit, resolving;

    assign {n, z, v} = flags;

    always_comb begin
        mask = {issue_opcode <= 4'd1,
                issue_opcode <= 4'd7 && issue_opcode != 4'd3 && issue_opcode != 4'd6,
                issue_opcode <= 4'd1};
        need = NEED[br_cond];
        busy = '0;
        for (int i = 0; i < PD; i++) busy |= pend[i];
        hazard = (EX_LAT > 1) && |(need & busy);
    end

    always_comb begin
        cond = 1'b1;
        case (br_cond)
            3'b000: cond = !z;
            3'b001: cond = z;
            3'b010: cond = !z && !n;
            3'b011: cond = n;
            3'b100: cond = z || !n;
            3'b101: cond = n || z;
            3'b110: cond = v;
            3'b111: cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = flush            ? IDLE :
                     state == HOLD    ? (fetch_ready ? IDLE : HOLD) :
                     !br_valid        ? IDLE :
                     hazard           ? WAIT :
                     fetch_ready      ? IDLE : HOLD;
    end

    always_comb begin
        br_resolved = rst && !flush && (state == HOLD || (br_valid && !hazard));
        br_taken    = br_resolved && (state == HOLD ? held : cond);
        stall       = rst && !flush && (state == HOLD || (br_valid && (hazard || !fetch_ready)));
        resolving   = br_resolved && state != HOLD;
        wait_hit    = !flush && state == WAIT && br_valid && hazard;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            cnt  <= '0;
            held <= 1'b0;
            err  <= 1'b0;
        end else begin
            pend[0] <= (issue_valid && !flush) ? mask : 3'b000;
            for (int i = 1; i < PD; i++) pend[i] <= flush ? 3'b000 : pend[i-1];
            cnt  <= !wait_hit ? '0 : (cnt < SMAX ? cnt + 1'b1 : cnt);
            held <= (resolving && !fetch_ready) ? cond : held;
            err  <= err || (wait_hit && cnt + 1'b1 >= SMAX);
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            taken_cnt    <= '0;
        end else begin
            stall_cycles <= stall_cycles + 16'(stall && stall_cycles != 16'hFFFF);
            taken_cnt    <= taken_cnt + 16'(br_resolved && fetch_ready && br_taken);
        end
    end
`endif
endmodule

// File: tb/tb_branch_flag_ctrl.sv
// tb_branch_flag_ctrl: directed and random checks of branch_flag_ctrl against a per-flag write-time model.
module tb_branch_flag_ctrl;
    localparam int EX_LAT    = 4;
    localparam int STALL_MAX = 2;

    logic       clk = 1'b0;
    logic       rst, issue_valid, br_valid, fetch_ready, flush;
    logic [3:0] issue_opcode;
    logic [2:0] flags, br_cond;
    logic       stall, br_resolved, br_taken, err;
`ifdef BRANCH_PERF_EN
    logic [15:0] stall_cycles, taken_cnt;
`endif

    always #5 clk = ~clk;

    branch_flag_ctrl #(.EX_LAT(EX_LAT), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .flags(flags), .br_valid(br_valid), .br_cond(br_cond), .fetch_ready(fetch_ready),
        .flush(flush), .stall(stall), .br_resolved(br_resolved), .br_taken(br_taken), .err(err)
`ifdef BRANCH_PERF_EN
        , .stall_cycles(stall_cycles), .taken_cnt(taken_cnt)
`endif
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk)
        if (rst && issue_valid) assert (!stall) else $error("issue while stalled");

    // Model: per flag, the cycle at which its latest writer writes back.
    int          cyc = 0;
    int          wt[3] = '{0, 0, 0};
    bit          m_wait, m_hold, m_held, m_err;
    int          m_cnt;
    bit [15:0]   m_sc, m_tc;

    function automatic bit [2:0] need_of(input bit [2:0] c);
        case (c)
            3'd0, 3'd1:       return 3'b010;
            3'd2, 3'd4, 3'd5: return 3'b110;
            3'd3:             return 3'b100;
            3'd6:             return 3'b001;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic bit cond_of(input bit [2:0] c, input bit [2:0] f);
        bit nf = f[2], zf = f[1], vf = f[0];
        case (c)
            3'd0: return !zf;
            3'd1: return zf;
            3'd2: return !zf && !nf;
            3'd3: return nf;
            3'd4: return zf || !nf;
            3'd5: return nf || zf;
            3'd6: return vf;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit [2:0] writes(input bit [3:0] op);
        return {op <= 1, op <= 7 && op != 3 && op != 6, op <= 1};
    endfunction

    task automatic model_clear();
        wt = '{0, 0, 0};
        m_wait = 0; m_hold = 0; m_held = 0; m_cnt = 0;
    endtask

    task automatic step(input string tag);
        bit hz, es, er, et;
        bit [2:0] nd, wr;
        nd = need_of(br_cond);
        hz = 0;
        for (int f = 0; f < 3; f++) if (nd[f] && wt[f] > cyc) hz = 1;
        es = 0; er = 0; et = 0;
        if (rst && !flush) begin
            if (m_hold) begin er = 1; et = m_held; es = 1; end
            else if (br_valid) begin
                if (hz) es = 1;
                else begin er = 1; et = cond_of(br_cond, flags); es = !fetch_ready; end
            end
        end
        if (es) issue_valid = 0;
        #1;
        check({tag, ".stall"}, stall, es);
        check({tag, ".resolved"}, br_resolved, er);
        if (er) check({tag, ".taken"}, br_taken, et);
        check({tag, ".err"}, err, rst ? m_err : 1'b0);
`ifdef BRANCH_PERF_EN
        check({tag, ".stall_cycles"}, stall_cycles, rst ? m_sc : 16'd0);
        check({tag, ".taken_cnt"}, taken_cnt, rst ? m_tc : 16'd0);
`endif
        @(posedge clk);
        if (!rst) begin
            model_clear();
            m_err = 0; m_sc = 0; m_tc = 0;
        end else begin
            if (es && m_sc != 16'hFFFF) m_sc++;
            if (er && fetch_ready && et) m_tc++;
            if (flush) model_clear();
            else begin
                if (issue_valid) begin
                    wr = writes(issue_opcode);
                    for (int f = 0; f < 3; f++) if (wr[f]) wt[f] = cyc + EX_LAT;
                end
                if (m_hold) begin
                    if (fetch_ready) m_hold = 0;
                end else if (br_valid && hz) begin
                    if (m_wait) begin
                        m_cnt++;
                        if (m_cnt >= STALL_MAX) m_err = 1;
                    end
                    m_wait = 1;
                end else begin
                    m_wait = 0; m_cnt = 0;
                    if (br_valid && !fetch_ready) begin m_hold = 1; m_held = et; end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_opcode = 0; br_valid = 0; br_cond = 0;
        fetch_ready = 1; flush = 0; flags = 0;
    endtask

    task automatic pulse_rst();
        rst = 0; idle_in(); step("rst_pulse");
        rst = 1; step("rst_rel");
    endtask

    initial begin
        rst = 0; idle_in(); br_valid = 1; br_cond = 3'b111;
        step("reset");
        rst = 1; idle_in();
        step("idle");
        // ADD then BEQ-style branch needing Z
        issue_valid = 1; issue_opcode = 4'd0; step("add_issue");
        issue_valid = 0; br_valid = 1; br_cond = 3'b001; flags = 3'b010;
        repeat (EX_LAT) step("z_wait");
        br_valid = 0; step("z_done");
        pulse_rst();
        // op 3 writes no Z
        issue_valid = 1; issue_opcode = 4'd3; step("op3_issue");
        issue_valid = 0; br_valid = 1; br_cond = 3'b001; flags = 3'b000; step("op3_br");
        br_valid = 0; step("op3_done");
        // Held decision while fetch is busy
        br_valid = 1; br_cond = 3'b110; flags = 3'b001; fetch_ready = 0;
        repeat (3) step("hold");
        fetch_ready = 1; step("hold_acc");
        br_valid = 0; step("hold_done");
        // Flush in the second WAIT cycle
        pulse_rst();
        issue_valid = 1; issue_opcode = 4'd0; step("fl_issue");
        issue_valid = 0; br_valid = 1; br_cond = 3'b011; flags = 3'b100;
        step("fl_wait1"); step("fl_wait2");
        flush = 1; step("fl_flush");
        flush = 0; step("fl_after");
        br_valid = 0; step("fl_done");
        // Watchdog via back-to-back writers
        pulse_rst();
        issue_valid = 1; issue_opcode = 4'd0;
        repeat (3) step("wd_issue");
        issue_valid = 0; br_valid = 1; br_cond = 3'b000; flags = 3'b000;
        repeat (EX_LAT) step("wd_wait");
        br_valid = 0; repeat (3) step("wd_sticky");
        // Async reset while holding
        br_valid = 1; br_cond = 3'b111; fetch_ready = 0;
        step("rh_res"); step("rh_hold");
        rst = 0; step("rh_rst");
        rst = 1; idle_in(); step("rh_after");
        repeat (3000) begin
            rst          = $urandom_range(0, 99) != 0;
            issue_valid  = $urandom_range(0, 2) != 0;
            issue_opcode = 4'($urandom);
            br_valid     = $urandom_range(0, 1) == 1;
            br_cond      = 3'($urandom);
            flags        = 3'($urandom);
            fetch_ready  = $urandom_range(0, 1) == 1;
            flush        = $urandom_range(0, 19) == 0;
            step("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
